cam_soc_from_hw_sig: RTL and testbench

Avalon-MM slave input port carrying status bits from camera/encryption hardware back to the Nios-side software. It is the companion to the existing software-to-hardware output port.
- Synchronizes the asynchronous hardware bits.
- Detects edges per bit, latches them in a sticky edge-capture register and raises a maskable level interrupt.
- Sits on the cam_soc system interconnect next to the output port.

---
 rtl/cam_soc_from_hw_sig.sv | 160 ++++++++++++++++
 tb/tb_cam_soc_from_hw_sig.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cam_soc_from_hw_sig.sv
// cam_soc_from_hw_sig: Avalon-MM input port returning status bits from the
// camera/encryption hardware to software. Bits are synchronised, optionally
// debounced, edge-detected into a sticky capture register and reported
// through a maskable level interrupt.
//
// Register map (word addresses):
//   0 data          read: current (synchronised / debounced) input bits
//   1 reserved      reads 0
//   2 irq_mask      read/write
//   3 edge_capture  read; write 1 to clear a bit
//
// Optional feature: define CAM_SOC_FROM_HW_SIG_DEBOUNCE_EN to insert a
// per-bit debounce filter of DEBOUNCE_CYCLES stable cycles after the
// synchroniser.
module cam_soc_from_hw_sig #(
    parameter int WIDTH           = 2,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [1:0] GUARD_DONE = 2'd3;

    // Elaboration-time sanity check of the configuration.
    if ((WIDTH < 1) || (WIDTH > 32) || (EDGE_TYPE < 0) || (EDGE_TYPE > 2) ||
        (DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > 65535)) begin : g_bad_param
        $error("cam_soc_from_hw_sig: parameter out of range");
    end

    logic [WIDTH-1:0] sync_q1;
    logic [WIDTH-1:0] sync_q2;
    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clear_bits;
    logic [1:0]       startup_cnt;
    logic             wr_en;
    logic             rd_en;
    logic [31:0]      read_mux;
    logic             unused_wd;

    // Only writedata[WIDTH-1:0] is meaningful; the upper bits are dropped.
    assign unused_wd = ^writedata;

    assign wr_en = chipselect & ~write_n;
    assign rd_en = chipselect & ~read_n;

    // Two-flop synchroniser for the asynchronous hardware bits.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source, independent of block order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= in_port;
            sync_q2 <= sync_q1;
        end
    end

`ifdef CAM_SOC_FROM_HW_SIG_DEBOUNCE_EN
    logic [15:0] db_cnt [WIDTH];

    // Per-bit debounce: follow sync_q2 only after DEBOUNCE_CYCLES of disagreement.
    // NOTE: this counter array is reset explicitly because its contents are
    // filter state, not storage; an unknown count would mis-time the first change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db <= '0;
            for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_q2[i] != db[i]) begin
                    if (db_cnt[i] == 16'(DEBOUNCE_CYCLES - 1)) begin
                        db[i]     <= sync_q2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 16'd1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end
`else
    assign db = sync_q2;
`endif

    // Previous-value register and startup guard counter (saturates at 3).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q      <= '0;
            startup_cnt <= '0;
        end else begin
            prev_q <= db;
            if (startup_cnt != GUARD_DONE) startup_cnt <= startup_cnt + 2'd1;
        end
    end

    // Edge selection, suppressed until the startup guard has expired.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rise = db & ~prev_q;
        fall = ~db & prev_q;
        case (EDGE_TYPE)
            0:       edge_det = rise;
            1:       edge_det = fall;
            default: edge_det = rise | fall;
        endcase
        if (startup_cnt != GUARD_DONE) edge_det = '0;
    end

    assign clear_bits = (wr_en && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;

    // Mask register and sticky capture register; a new edge beats a clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask     <= '0;
            edge_capture <= '0;
        end else begin
            if (wr_en && (address == 2'd2)) irq_mask <= writedata[WIDTH-1:0];
            edge_capture <= (edge_capture & ~clear_bits) | edge_det;
        end
    end

    // Read decode, zero-extended to the 32-bit bus.
    always_comb begin
        read_mux = '0;
        case (address)
            2'd0:    read_mux[WIDTH-1:0] = db;
            2'd2:    read_mux[WIDTH-1:0] = irq_mask;
            2'd3:    read_mux[WIDTH-1:0] = edge_capture;
            default: read_mux = '0;
        endcase
    end

    // Registered read data, held until the next read strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else if (rd_en) readdata <= read_mux;
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_cam_soc_from_hw_sig.sv
// Directed bench for cam_soc_from_hw_sig. Two instances share the bus: dut0
// captures rising edges, dut2 captures both edges. All steps start and end
// on a falling clock edge; the DUT samples on the rising edge in between.
module tb_cam_soc_from_hw_sig;

`ifdef CAM_SOC_FROM_HW_SIG_DEBOUNCE_EN
    localparam int          XL    = 16;
    localparam logic [31:0] T1_EC = 32'h3;  // debounced rise lands after the guard
`else
    localparam int          XL    = 0;
    localparam logic [31:0] T1_EC = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata0, readdata2;
    logic [1:0]  in0, in2;
    logic        irq0, irq2;
    logic [31:0] r0, r2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cam_soc_from_hw_sig #(.WIDTH(2), .EDGE_TYPE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .readdata(readdata0), .in_port(in0), .irq(irq0)
    );

    cam_soc_from_hw_sig #(.WIDTH(2), .EDGE_TYPE(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .readdata(readdata2), .in_port(in2), .irq(irq2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d0, output logic [31:0] d2);
        chipselect = 1'b1; read_n = 1'b0; address = a;
        @(negedge clk);
        chipselect = 1'b0; read_n = 1'b1;
        d0 = readdata0;
        d2 = readdata2;
    endtask

    initial begin
        reset_n = 1'b0; address = '0; chipselect = 1'b0; read_n = 1'b1;
        write_n = 1'b1; writedata = '0; in0 = 2'b11; in2 = 2'b00;
        tick(2);
        check("reset_readdata", readdata0, 32'h0);
        check("reset_irq", {31'b0, irq0}, 32'h0);

        // 1: bits high at reset release are visible but capture no edge
        reset_n = 1'b1;
        tick(5 + XL);
        bus_read(2'd0, r0, r2);
        check("t1_data", r0, 32'h3);
        bus_read(2'd3, r0, r2);
        check("t1_capture", r0, T1_EC);
        check("t1_irq", {31'b0, irq0}, 32'h0);
        bus_read(2'd1, r0, r2);
        check("t1_reserved", r0, 32'h0);
        bus_write(2'd0, 32'hFFFF_FFFF);          // data port ignores writes
        bus_write(2'd3, 32'h3);
        bus_read(2'd0, r0, r2);
        check("t1_data_after_write", r0, 32'h3);

        // 2: falling edge ignored, rising edge captured two edges after sampling
        in0 = 2'b00;
        tick(3 + XL);
        bus_read(2'd3, r0, r2);
        check("t2_fall_ignored", r0, 32'h0);
        bus_write(2'd2, 32'h1);
        bus_read(2'd2, r0, r2);
        check("t2_mask_rd", r0, 32'h1);
        in0 = 2'b01;
        tick(2 + XL);
        check("t2_irq_before", {31'b0, irq0}, 32'h0);
        tick(1);
        check("t2_irq_set", {31'b0, irq0}, 32'h1);
        bus_read(2'd3, r0, r2);
        check("t2_capture", r0, 32'h1);
        bus_write(2'd3, 32'h1);
        check("t2_irq_cleared", {31'b0, irq0}, 32'h0);
        bus_read(2'd3, r0, r2);
        check("t2_capture_cleared", r0, 32'h0);

        // 3: clear of bit 1 in the same cycle its edge lands -> set wins
        in0 = 2'b11;
        tick(2 + XL);
        bus_write(2'd3, 32'h2);
        bus_read(2'd3, r0, r2);
        check("t3_set_wins", r0, 32'h2);
        check("t3_irq_masked", {31'b0, irq0}, 32'h0);
        bus_write(2'd3, 32'h2);
        bus_read(2'd3, r0, r2);
        check("t3_clear", r0, 32'h0);

        // 4: capture while masked, then unmask -> irq the next cycle
        bus_write(2'd2, 32'h0);
        in0 = 2'b10;
        tick(3 + XL);
        in0 = 2'b11;
        tick(3 + XL);
        check("t4_irq_masked", {31'b0, irq0}, 32'h0);
        bus_read(2'd3, r0, r2);
        check("t4_capture", r0, 32'h1);
        check("t4_hold_pre", {31'b0, irq0}, 32'h0);
        bus_write(2'd2, 32'h1);
        check("t4_irq_unmasked", {31'b0, irq0}, 32'h1);
        tick(3);
        check("t4_readdata_held", readdata0, 32'h1);

        // Reset mid-operation clears everything at once
        reset_n = 1'b0;
        #1;
        check("mid_reset_irq", {31'b0, irq0}, 32'h0);
        check("mid_reset_readdata", readdata0, 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(5 + XL);
        bus_read(2'd3, r0, r2);
        check("mid_reset_capture", r0, T1_EC);
        bus_read(2'd2, r0, r2);
        check("mid_reset_mask", r0, 32'h0);
        bus_write(2'd3, 32'h3);

        // Upper writedata bits of the mask are dropped, readback zero-extended
        bus_write(2'd2, 32'hFFFF_FFFE);
        bus_read(2'd2, r0, r2);
        check("mask_upper_ignored", r0, 32'h2);

`ifndef CAM_SOC_FROM_HW_SIG_DEBOUNCE_EN
        // 5: any-edge instance, clear between rise and fall -> fall re-sets
        bus_write(2'd3, 32'h3);
        bus_write(2'd2, 32'h1);
        in2 = 2'b01;
        tick(3);
        in2 = 2'b00;
        bus_read(2'd3, r0, r2);
        check("t5_rise", r2, 32'h1);
        check("t5_irq_rise", {31'b0, irq2}, 32'h1);
        bus_write(2'd3, 32'h1);
        check("t5_irq_cleared", {31'b0, irq2}, 32'h0);
        tick(1);
        check("t5_irq_fall", {31'b0, irq2}, 32'h1);
        bus_read(2'd3, r0, r2);
        check("t5_fall", r2, 32'h1);
        check("t5_rising_only_dut", r0, 32'h0);
`else
        // 6: 10-cycle glitch is filtered, 20-cycle level gets through
        in0 = 2'b00;
        tick(XL + 4);
        bus_write(2'd3, 32'h3);
        in0 = 2'b01;
        tick(10);
        in0 = 2'b00;
        tick(30);
        bus_read(2'd0, r0, r2);
        check("t6_glitch_data", r0, 32'h0);
        bus_read(2'd3, r0, r2);
        check("t6_glitch_capture", r0, 32'h0);
        in0 = 2'b01;
        tick(20);
        bus_read(2'd0, r0, r2);
        check("t6_level_data", r0, 32'h1);
        tick(2);
        bus_read(2'd3, r0, r2);
        check("t6_level_capture", r0, 32'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
